hex_digit_scanner: RTL and testbench



---
 rtl/hex_disp_pkg.sv | 18 +
 rtl/hex_digit_scanner_tick_divider.sv | 31 +++
 rtl/hex_digit_scanner.sv | 100 ++++++++++
 tb/tb_hex_digit_scanner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the debug-board hex display blocks.
package hex_disp_pkg;

  localparam int DEF_NUM_DIGITS    = 8;
  localparam int DEF_TICK_DIV      = 50000;
  localparam int DEF_BLANK_LEADING = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Index/counter width for n values, never narrower than one bit.
  function automatic int digit_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_digit_scanner_tick_divider.sv
// Free-running slot divider: tick pulses once every TICK_DIV enabled cycles.
module tick_divider
  import hex_disp_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = digit_idx_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  assign tick = enable && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/hex_digit_scanner.sv
// Multiplexed seven-segment scanner; new words are taken only at frame boundaries
// so a frame never mixes old and new digits.
module hex_digit_scanner
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int BLANK_LEADING = DEF_BLANK_LEADING
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    blank,
  output logic                    dp_n
);

  localparam int IDX_W = digit_idx_w(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t               state_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic [4*NUM_DIGITS-1:0]   shadow_reg;
  logic [NUM_DIGITS-1:0]     shadow_dp_reg;
  logic                      tick;
  logic                      transfer;
  logic                      lit;
  logic [3:0]                digits [NUM_DIGITS];
  logic [NUM_DIGITS:0]       zero_from;
  logic [NUM_DIGITS-1:0]     suppress;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_reg == IDLE),
    .enable (state_reg == SCAN),
    .tick   (tick)
  );

  assign load_ready = (state_reg == IDLE) || (tick && (idx_reg == LAST_IDX));
  assign transfer   = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      shadow_reg    <= '0;
      shadow_dp_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            shadow_reg    <= load_data;
            shadow_dp_reg <= load_dp;
            idx_reg       <= '0;
            state_reg     <= SCAN;
          end
        end
        SCAN: begin
          if (tick) begin
            idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
          end
          // Only possible on the last-digit tick, i.e. together with the wrap to 0.
          if (transfer) begin
            shadow_reg    <= load_data;
            shadow_dp_reg <= load_dp;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // zero_from[i]: every digit from i up to the top one is zero.
  assign zero_from[NUM_DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digits[gi]    = shadow_reg[4*gi +: 4];
      assign zero_from[gi] = (shadow_reg[4*gi +: 4] == 4'h0) && zero_from[gi+1];
      if (gi == 0) begin : g_first
        assign suppress[gi] = 1'b0;
      end else begin : g_rest
        assign suppress[gi] = (BLANK_LEADING != 0) && zero_from[gi];
      end
      assign digit_en_n[gi] = !(lit && (idx_reg == IDX_W'(gi)));
    end
  endgenerate

  assign lit    = (state_reg == SCAN) && !suppress[idx_reg];
  assign nibble = digits[idx_reg];
  assign blank  = !lit;
  assign dp_n   = !(lit && shadow_dp_reg[idx_reg]);

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Randomized and directed bench for hex_digit_scanner against a frame/slot model.
module tb_hex_digit_scanner;

  localparam int N  = 8;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [31:0]   load_data = '0;
  logic [7:0]    load_dp = '0;
  logic [3:0]    nibble;
  logic [7:0]    digit_en_n;
  logic          blank;
  logic          dp_n;

  int vectors = 0;
  int miscompares = 0;

  hex_digit_scanner #(.NUM_DIGITS(N), .TICK_DIV(TD), .BLANK_LEADING(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .nibble     (nibble),
    .digit_en_n (digit_en_n),
    .blank      (blank),
    .dp_n       (dp_n)
  );

  always #5 clk = ~clk;

  // Model: 'phase' counts cycles within a frame; slot = phase / TD.
  bit         m_scan = 1'b0;
  int         phase = 0;
  logic [3:0] m_dig [N] = '{default: 4'h0};
  logic [7:0] m_dp = '0;

  function automatic int m_slot();
    return phase / TD;
  endfunction

  function automatic bit m_ready();
    return !m_scan || (((phase % TD) == TD - 1) && (m_slot() == N - 1));
  endfunction

  function automatic bit m_suppressed();
    int s;
    s = m_slot();
    if (s == 0) return 1'b0;
    for (int i = s; i < N; i++) if (m_dig[i] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan <= 1'b0;
      phase  <= 0;
      m_dp   <= '0;
      for (int i = 0; i < N; i++) m_dig[i] <= 4'h0;
    end else begin
      if (load_valid && m_ready()) begin
        for (int i = 0; i < N; i++) m_dig[i] <= load_data[4*i +: 4];
        m_dp <= load_dp;
      end
      if (!m_scan) begin
        if (load_valid) m_scan <= 1'b1;
      end else begin
        phase <= (phase + 1) % (TD * N);
      end
    end
  end

  task automatic check_cycle();
    bit         lit;
    int         s;
    logic [3:0] e_nib;
    logic [7:0] e_en;
    logic       e_blank, e_dp, e_rdy;
    s       = m_slot();
    lit     = m_scan && !m_suppressed();
    e_nib   = m_dig[s];
    e_en    = lit ? ~(8'h01 << s) : 8'hFF;
    e_blank = !lit;
    e_dp    = !(lit && m_dp[s]);
    e_rdy   = m_ready();
    vectors++;
    if (nibble !== e_nib || digit_en_n !== e_en || blank !== e_blank ||
        dp_n !== e_dp || load_ready !== e_rdy) begin
      miscompares++;
      $display("FAIL cycle @%0t: nibble %h/%h en %h/%h blank %b/%b dp_n %b/%b ready %b/%b (got/exp)",
               $time, nibble, e_nib, digit_en_n, e_en, blank, e_blank, dp_n, e_dp, load_ready, e_rdy);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic load_word(input logic [31:0] d, input logic [7:0] p, output int n);
    bit took;
    load_valid = 1'b1;
    load_data  = d;
    load_dp    = p;
    n = 0;
    took = 1'b0;
    do begin
      @(negedge clk);
      took = load_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 200);
    if (!took) chk("load timeout", 32'(n), 32'hFFFF_FFFF);
    load_valid = 1'b0;
    load_data  = $urandom;
    load_dp    = 8'($urandom);
  endtask

  logic [3:0] seq_nib [8] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
  logic [7:0] seq_en  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial begin
    int n;
    #1 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        check_cycle();
      end
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Reset state holds while idle
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("reset en", 32'(digit_en_n), 32'hFF);
      chk("reset blank/dp/ready/nib", {blank, dp_n, load_ready, nibble}, {3'b111, 4'h0});
    end

    // Full scan from IDLE
    @(posedge clk); #1;
    load_word(32'h1234ABCD, 8'h00, n);
    chk("idle accept latency", 32'(n), 32'd1);
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      chk("scan nibble", 32'(nibble), 32'(seq_nib[j % 8]));
      chk("scan en", 32'(digit_en_n), 32'(seq_en[j % 8]));
      if (j < 8) repeat (TD - 1) @(negedge clk);
    end

    // Leading-zero blanking
    @(posedge clk); #1;
    load_word(32'h000000A5, 8'h00, n);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j == 0) chk("lz d0", {blank, nibble, digit_en_n}, {1'b0, 4'h5, 8'hFE});
      if (j == 1) chk("lz d1", {blank, nibble, digit_en_n}, {1'b0, 4'hA, 8'hFD});
      if (j == 2) chk("lz d2 blank", {blank, digit_en_n}, {1'b1, 8'hFF});
      repeat (TD - 1) @(negedge clk);
    end
    @(posedge clk); #1;
    load_word(32'h0, 8'h00, n);
    @(negedge clk);
    chk("zero d0", {blank, nibble, digit_en_n}, {1'b0, 4'h0, 8'hFE});
    repeat (TD) @(negedge clk);
    chk("zero d1 blank", {blank, digit_en_n}, {1'b1, 8'hFF});

    // Decimal point on digit 2 only
    @(posedge clk); #1;
    load_word(32'h87654321, 8'h04, n);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("dp slot", 32'(dp_n), (j == 2) ? 32'd0 : 32'd1);
      repeat (TD - 1) @(negedge clk);
    end

    // Hold valid from idx 3; transfer only at the idx-7 tick
    @(posedge clk); #1;
    load_word(32'h87654321, 8'h00, n);
    repeat (12) @(posedge clk);
    #1;
    @(negedge clk);
    chk("old digit 3", {nibble, digit_en_n}, {4'h4, 8'hF7});
    @(posedge clk); #1;
    load_word(32'hDEADBEEF, 8'h00, n);
    chk("hold cycles until wrap", 32'(n), 32'd19);
    @(negedge clk);
    chk("new frame d0", {nibble, digit_en_n}, {4'hF, 8'hFE});

    // Async reset mid-scan at idx 5
    @(posedge clk); #1;
    load_word(32'h13572468, 8'h00, n);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("pre-reset idx5", 32'(digit_en_n), 32'hDF);
    #2 rst_n = 1'b0;
    #1;
    chk("async dark", {blank, dp_n, load_ready, digit_en_n}, {3'b111, 8'hFF});
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle after reset", {blank, nibble, digit_en_n}, {1'b1, 4'h0, 8'hFF});
    @(posedge clk); #1;
    load_word(32'h0000009C, 8'h00, n);
    chk("restart accept", 32'(n), 32'd1);
    @(negedge clk);
    chk("restart d0", {nibble, digit_en_n}, {4'hC, 8'hFE});

    // Random traffic, checked every cycle against the model
    @(posedge clk); #1;
    for (int c = 0; c < 2000; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 32'($urandom) >> (4 * $urandom_range(0, 8));
      load_dp    = 8'($urandom);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
